// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial add/subtract engine: FSM state
// encoding and operation-mode constants.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_full_adder.sv
// One-bit full adder built from two half adders and an OR; the single
// arithmetic cell that the serial engine reuses every cycle.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_hs, w_hc, w_hc2;

  assign w_hs  = a ^ b;
  assign w_hc  = a & b;
  assign s     = w_hs ^ cin;
  assign w_hc2 = w_hs & cin;
  assign cout  = w_hc | w_hc2;

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit add/subtract: operands in over valid/ready, one result
// bit per enabled cycle LSB-first, sum and flags out over valid/ready.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic [WIDTH-1:0]   r_sa, r_sb, r_sum;
  logic               r_cout, r_ovf, r_zero;

  logic               w_accept, w_last, w_fa_s, w_fa_c;
  logic [WIDTH-1:0]   w_sum_nxt;

  assign in_ready  = (r_state == IDLE) & ena;
  assign out_valid = (r_state == DONE);
  assign w_accept  = in_valid & in_ready;
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_sum_nxt = {w_fa_s, r_sum[WIDTH-1:1]};

  full_adder u_fa (
    .a    (r_sa[0]),
    .b    (r_sb[0]),
    .cin  (r_carry),
    .s    (w_fa_s),
    .cout (w_fa_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)            w_state_nxt = RUN;
      RUN:     if (ena && w_last)       w_state_nxt = DONE;
      DONE:    if (ena && out_ready)    w_state_nxt = IDLE;
      default:                          w_state_nxt = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: B is inverted on capture and the +1 enters
  // as the initial carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sa    <= '0;
      r_sb    <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (ena) begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_sa    <= a;
          r_sb    <= (sub == OP_SUB) ? ~b : b;
          r_carry <= (sub == OP_SUB);
          r_cnt   <= '0;
          r_sum   <= '0;
        end
        RUN: begin
          r_sum   <= w_sum_nxt;
          r_sa    <= r_sa >> 1;
          r_sb    <= r_sb >> 1;
          r_carry <= w_fa_c;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_ovf  <= r_carry ^ w_fa_c;
            r_cout <= w_fa_c;
            r_zero <= (w_sum_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;
  assign zero = r_zero;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub (WIDTH=8): vector table plus hand-written
// backpressure, clock-enable freeze and mid-operation reset sequences.
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, ena, in_valid, in_ready, sub;
  logic         out_valid, out_ready, cout, ovf, zero;
  logic [W-1:0] a, b, sum;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
    logic         ez;
  } vec_t;

  vec_t vt[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Issue one operation and wait (bounded) for out_valid. Operands are
  // scrambled and in_valid held high after acceptance to prove they are
  // ignored. Optional ena freeze of frz_len cycles after frz_at edges.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                        input int frz_at, input int frz_len,
                        output int lat, output logic bad);
    bad = 1'b0;
    @(negedge clk);
    a = ta; b = tb; sub = ts; in_valid = 1'b1;
    if (!in_ready) bad = 1'b1;
    @(negedge clk);
    a = ~ta; b = ~tb; sub = ~ts;
    lat = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) bad = 1'b1;
      if (lat == frz_at) begin
        ena = 1'b0;
        repeat (frz_len) begin
          @(negedge clk);
          lat++;
          if (in_ready || out_valid) bad = 1'b1;
        end
        ena = 1'b1;
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid drops after handshake", {31'd0, out_valid}, 32'd0);
    check("in_ready back in IDLE", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int           lat;
    logic         bad, stable;
    logic [W-1:0] held;

    vt[0] = '{8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 1'b0, 1'b0};
    vt[1] = '{8'd100, 8'd100, 1'b0, 8'hC8,  1'b0, 1'b1, 1'b0};
    vt[2] = '{8'd5,   8'd7,   1'b1, 8'hFE,  1'b0, 1'b0, 1'b0};
    vt[3] = '{8'h80,  8'h01,  1'b1, 8'h7F,  1'b1, 1'b1, 1'b0};
    vt[4] = '{8'h80,  8'h80,  1'b0, 8'h00,  1'b1, 1'b1, 1'b1};
    vt[5] = '{8'd37,  8'd58,  1'b0, 8'd95,  1'b0, 1'b0, 1'b0};
    vt[6] = '{8'h55,  8'h55,  1'b1, 8'h00,  1'b1, 1'b0, 1'b1};
    vt[7] = '{8'hFF,  8'h01,  1'b0, 8'h00,  1'b1, 1'b0, 1'b1};
    vt[8] = '{8'h7F,  8'h01,  1'b0, 8'h80,  1'b0, 1'b1, 1'b0};
    vt[9] = '{8'h00,  8'h01,  1'b1, 8'hFF,  1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0;
    repeat (2) @(negedge clk);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset sum", {24'd0, sum}, 32'd0);
    check("reset flags", {29'd0, cout, ovf, zero}, 32'd0);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    ena = 1'b0; #1;
    check("in_ready gated by ena", {31'd0, in_ready}, 32'd0);
    ena = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].s, -1, 0, lat, bad);
      check($sformatf("v%0d latency", i), lat, W);
      check($sformatf("v%0d handshake/busy", i), {31'd0, bad}, 32'd0);
      check($sformatf("v%0d sum", i), {24'd0, sum}, {24'd0, vt[i].es});
      check($sformatf("v%0d cout/ovf/zero", i), {29'd0, cout, ovf, zero},
            {29'd0, vt[i].ec, vt[i].eo, vt[i].ez});
      if (i == 0) begin
        held   = sum;
        stable = 1'b1;
        repeat (10) begin
          @(negedge clk);
          if (!out_valid || sum !== held) stable = 1'b0;
        end
        check("backpressure hold", {31'd0, stable}, 32'd1);
      end
      take_result();
    end

    run_op(8'd37, 8'd58, 1'b0, 3, 3, lat, bad);
    check("ena freeze latency", lat, W + 3);
    check("ena freeze busy", {31'd0, bad}, 32'd0);
    check("ena freeze sum", {24'd0, sum}, 32'd95);
    // out_ready must be ignored while ena is low
    ena = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("out_ready ignored when ena low", {31'd0, out_valid}, 32'd1);
    ena = 1'b1; out_ready = 1'b0;
    take_result();

    @(negedge clk);
    a = 8'hFF; b = 8'h01; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0; #1;
    check("mid-run reset sum", {24'd0, sum}, 32'd0);
    check("mid-run reset flags/valid", {28'd0, out_valid, cout, ovf, zero}, 32'd0);
    check("mid-run reset in_ready", {31'd0, in_ready}, {31'd0, ena});
    @(negedge clk);
    rst_n = 1'b1;
    stable = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) stable = 1'b0;
    end
    check("no spurious out_valid after reset", {31'd0, stable}, 32'd1);
    run_op(8'd3, 8'd4, 1'b0, -1, 0, lat, bad);
    check("post-reset latency", lat, W);
    check("post-reset sum", {24'd0, sum}, 32'd7);
    check("post-reset flags", {29'd0, cout, ovf, zero}, 32'd0);
    take_result();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
